// File: rtl/fbrc_pkg.sv
// fbrc_pkg: shared state encodings and mode constants for the run/stop sequencer
package fbrc_pkg;
  typedef enum logic [1:0] {
    FBRC_IDLE  = 2'b00,
    FBRC_RUN   = 2'b01,
    FBRC_PAUSE = 2'b10,
    FBRC_DONE  = 2'b11
  } fbrc_state_e;
  localparam logic FBRC_ONESHOT = 1'b0;
  localparam logic FBRC_RELOAD  = 1'b1;
endpackage

// File: rtl/fbrc_sync_cnt.sv
// fbrc_sync_cnt: synchronous up-counter with clear and enable
module fbrc_sync_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (en) q <= q + WIDTH'(1);
endmodule

// File: rtl/fbrc_run_ctrl.sv
// fbrc_run_ctrl: run/stop sequencer driving a counter to a latched terminal count
module fbrc_run_ctrl
  import fbrc_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEFAULT_TC = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] tc_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);
  fbrc_state_e      st;
  logic [WIDTH-1:0] tc_reg;
  logic             mode_reg;
  logic             match, go, clr, en;
  assign busy  = st == FBRC_RUN || st == FBRC_PAUSE;
  assign state = st;
  assign match = q == tc_reg;
  // leaving PAUSE evaluates like RUN so each paused edge costs exactly one cycle
  assign go    = busy && !pause && !stop && !start;
  assign clr   = stop || start || (go && match && mode_reg == FBRC_RELOAD);
  assign en    = go && !match;
  fbrc_sync_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .rst (reset),
    .clr (clr),
    .en  (en),
    .q   (q)
  );
  always_ff @(posedge clk)
    if (reset) begin
      st       <= FBRC_IDLE;
      tc_reg   <= WIDTH'(DEFAULT_TC);
      mode_reg <= FBRC_ONESHOT;
      done     <= 1'b0;
    end else begin
      done <= go && match;
      if (stop) st <= FBRC_IDLE;
      else if (start) begin
        st       <= FBRC_RUN;
        tc_reg   <= tc_in;
        mode_reg <= mode;
      end else if (busy)
        st <= pause ? FBRC_PAUSE : (match && mode_reg == FBRC_ONESHOT) ? FBRC_DONE : FBRC_RUN;
    end
endmodule
